// File: rtl/module_control_mult.sv
// ============================================================================
// Module   : module_control_mult
// Purpose  : Keypad entry controller for a two-operand BCD-to-binary multiply.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module module_control_mult #(
  parameter int N_DIGITOS = 2,
  parameter int OP_W      = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      dato_i,
  input  logic            dato_listo_i,
  input  logic            enter_i,
  input  logic            borrar_i,
  input  logic            mult_done_i,
  output logic [OP_W-1:0] op_a_o,
  output logic [OP_W-1:0] op_b_o,
  output logic            mult_start_o,
  output logic            listo_o,
  output logic            error_o,
  output logic [2:0]      estado_o
);

  localparam int CW = $clog2(N_DIGITOS + 1);
  localparam logic [CW-1:0] c_max_cnt = CW'(N_DIGITOS);

  typedef enum logic [2:0] {
    CAP_A    = 3'd0,
    CAP_B    = 3'd1,
    ARRANQUE = 3'd2,
    ESPERA   = 3'd3,
    LISTO    = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [OP_W-1:0] r_op_a, r_op_b, w_op_a_nxt, w_op_b_nxt;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic            r_error, w_error_nxt;

  logic [OP_W-1:0] w_active;
  logic [OP_W-1:0] w_shift_add;
  logic            w_digit_ok;

  assign w_digit_ok  = (dato_i < 4'd10);
  assign w_active    = (r_state == CAP_B) ? r_op_b : r_op_a;
  // Only used while count < N_DIGITOS, so the product always fits in OP_W bits
  assign w_shift_add = (w_active << 3) + (w_active << 1) + OP_W'(dato_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= CAP_A;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op_a  <= w_op_a_nxt;
      r_op_b  <= w_op_b_nxt;
      r_count <= w_count_nxt;
      r_error <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_a_nxt  = r_op_a;
    w_op_b_nxt  = r_op_b;
    w_count_nxt = r_count;
    w_error_nxt = 1'b0;

    case (r_state)
      CAP_A, CAP_B: begin
        if (borrar_i) begin
          w_state_nxt = CAP_A;
          w_op_a_nxt  = '0;
          w_op_b_nxt  = '0;
          w_count_nxt = '0;
        end else if (enter_i) begin
          if (r_count == '0) begin
            w_error_nxt = 1'b1;
          end else if (r_state == CAP_A) begin
            w_state_nxt = CAP_B;
            w_count_nxt = '0;
          end else begin
            w_state_nxt = ARRANQUE;
          end
        end else if (dato_listo_i) begin
          if (!w_digit_ok || (r_count == c_max_cnt)) begin
            w_error_nxt = 1'b1;
          end else begin
            if (r_state == CAP_A) w_op_a_nxt = w_shift_add;
            else                  w_op_b_nxt = w_shift_add;
            w_count_nxt = r_count + CW'(1);
          end
        end
      end

      ARRANQUE: w_state_nxt = ESPERA;

      ESPERA: begin
        if (mult_done_i) w_state_nxt = LISTO;
      end

      LISTO: begin
        if (borrar_i) begin
          w_state_nxt = CAP_A;
          w_op_a_nxt  = '0;
          w_op_b_nxt  = '0;
          w_count_nxt = '0;
        end else if (enter_i) begin
          w_error_nxt = 1'b1;
        end else if (dato_listo_i) begin
          if (w_digit_ok) begin
            w_state_nxt = CAP_A;
            w_op_a_nxt  = OP_W'(dato_i);
            w_op_b_nxt  = '0;
            w_count_nxt = CW'(1);
          end else begin
            w_error_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = CAP_A;
        w_op_a_nxt  = '0;
        w_op_b_nxt  = '0;
        w_count_nxt = '0;
      end
    endcase
  end

  assign op_a_o       = r_op_a;
  assign op_b_o       = r_op_b;
  assign mult_start_o = (r_state == ARRANQUE);
  assign listo_o      = (r_state == LISTO);
  assign error_o      = r_error;
  assign estado_o     = r_state;

endmodule

`default_nettype wire
